// File: rtl/sync_pchb_merge_if.sv
// sync_pchb_merge_if
// Bundles the dual-rail channels around the clocked merge.
//   L0, L1     : dual-rail input tokens   (master -> slave)
//   L0e, L1e   : input enables            (slave  -> master)
//   R          : dual-rail merged output  (slave  -> master)
//   Re         : R receiver enable        (master -> slave)
//   SELECT     : dual-rail source token   (slave  -> master)
//   SELECTe    : SELECT receiver enable   (master -> slave)
//   ERR        : sticky illegal-code flag (slave  -> master)
// The merge itself uses the slave modport.
interface sync_pchb_merge_if;
  logic [1:0] L0;
  logic [1:0] L1;
  logic [1:0] R;
  logic [1:0] SELECT;
  logic       L0e;
  logic       L1e;
  logic       Re;
  logic       SELECTe;
  logic       ERR;

  modport master (
    output L0, L1, Re, SELECTe,
    input  L0e, L1e, R, SELECT, ERR
  );

  modport slave (
    input  L0, L1, Re, SELECTe,
    output L0e, L1e, R, SELECT, ERR
  );
endinterface

// File: rtl/sync_pchb_merge.sv
// sync_pchb_merge
// Clocked two-input merge for dual-rail four-phase channels. It arbitrates
// between L0 and L1, forwards the winning token on R and emits a SELECT
// token naming the source input. All asynchronous inputs are synchronized
// and all outputs are registered.
// Ports:
//   CLK   : sole clock, rising edge
//   RESET : asynchronous, active-high
//   ch    : channel bundle (slave side), see sync_pchb_merge_if
// Parameter:
//   SYNC_STAGES : synchronizer depth for L0, L1, Re, SELECTe (1..3)
//
// state      | meaning
// -----------+--------------------------------------------------------
// ST_IDLE    | both enables high, outputs neutral, waiting for a token
// ST_SEND    | winner forwarded on R/SELECT, waiting for Re/SELECTe low
// ST_RELEASE | outputs neutral, waiting for receivers ready and the
//            | winner's input back to neutral
module sync_pchb_merge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic          CLK,
  input  logic          RESET,
  sync_pchb_merge_if.slave ch
);

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_RELEASE} state_t;

  // Synchronizer chain, one 6-bit word per stage: {SELECTe, Re, L1, L0}.
  logic [5:0] sync_q [SYNC_STAGES];

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 6'b0;
    end else begin
      sync_q[0] <= {ch.SELECTe, ch.Re, ch.L1, ch.L0};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  logic [1:0] s_l0, s_l1;
  logic       s_re, s_sele;

  assign s_l0   = sync_q[SYNC_STAGES-1][1:0];
  assign s_l1   = sync_q[SYNC_STAGES-1][3:2];
  assign s_re   = sync_q[SYNC_STAGES-1][4];
  assign s_sele = sync_q[SYNC_STAGES-1][5];

  logic v0, v1, bad0, bad1;
  assign v0   = s_l0[1] ^ s_l0[0];
  assign v1   = s_l1[1] ^ s_l1[0];
  assign bad0 = &s_l0;
  assign bad1 = &s_l1;

  state_t     state_q, state_d;
  logic [1:0] r_q, r_d, sel_q, sel_d;
  logic       l0e_q, l0e_d, l1e_q, l1e_d;
  logic       win_q, win_d, last_q, last_d, err_q, err_d;

  logic go, drop, rel, grant1;

  // L1 takes a contended grant unless it won the previous token.
  assign grant1 = v1 & (~v0 | ~last_q);
  assign go     = s_re & s_sele & (v0 | v1);
  assign drop   = ~s_re & ~s_sele;
  assign rel    = s_re & s_sele & (win_q ? (s_l1 == 2'b00) : (s_l0 == 2'b00));

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      r_q     <= 2'b00;
      sel_q   <= 2'b00;
      l0e_q   <= 1'b1;
      l1e_q   <= 1'b1;
      win_q   <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      sel_q   <= sel_d;
      l0e_q   <= l0e_d;
      l1e_q   <= l1e_d;
      win_q   <= win_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (go)   state_d = ST_SEND;
      ST_SEND:    if (drop) state_d = ST_RELEASE;
      ST_RELEASE: if (rel)  state_d = ST_IDLE;
      default:              state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs; they only move on the same
  // transitions as the state, so R and SELECT always change together.
  always_comb begin
    r_d    = r_q;
    sel_d  = sel_q;
    l0e_d  = l0e_q;
    l1e_d  = l1e_q;
    win_d  = win_q;
    last_d = last_q;
    err_d  = err_q | bad0 | bad1;
    case (state_q)
      ST_IDLE: begin
        if (go) begin
          win_d = grant1;
          r_d   = grant1 ? s_l1 : s_l0;
          sel_d = grant1 ? 2'b10 : 2'b01;
          l0e_d = grant1;
          l1e_d = ~grant1;
        end
      end
      ST_SEND: begin
        if (drop) begin
          r_d   = 2'b00;
          sel_d = 2'b00;
        end
      end
      ST_RELEASE: begin
        if (rel) begin
          l0e_d  = 1'b1;
          l1e_d  = 1'b1;
          last_d = win_q;
        end
      end
      default: begin
        r_d   = 2'b00;
        sel_d = 2'b00;
      end
    endcase
  end

  assign ch.R      = r_q;
  assign ch.SELECT = sel_q;
  assign ch.L0e    = l0e_q;
  assign ch.L1e    = l1e_q;
  assign ch.ERR    = err_q;

endmodule

// File: tb/tb_sync_pchb_merge.sv
// tb_sync_pchb_merge
// Directed bench for sync_pchb_merge with SYNC_STAGES=2. A negedge
// process keeps a pin-history model (inputs seen SYNC_STAGES+1 edges
// earlier decide each grant) and checks ERR, the R/SELECT pairing and the
// enable rules every cycle; the directed sequence pins latencies and the
// arbitration order with literal values.
module tb_sync_pchb_merge;
  localparam int S = 2;

  logic CLK;
  logic RESET;
  sync_pchb_merge_if bus();

  sync_pchb_merge #(.SYNC_STAGES(S)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .ch    (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- model / per-cycle compare ----------------
  logic [3:0] h [0:4];
  logic [3:0] hv;
  logic [1:0] p0, p1, prev_r;
  logic       mlast, merr, prev_l0e, prev_l1e, v0, v1, w;
  int         cur_win;
  int         grants[$];

  always @(negedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < 5; i++) h[i] = 4'b0;
      merr = 1'b0; mlast = 1'b0; prev_r = 2'b00;
      prev_l0e = 1'b1; prev_l1e = 1'b1; cur_win = -1;
    end else begin
      for (int i = 4; i > 0; i--) h[i] = h[i-1];
      h[0] = {bus.L1, bus.L0};
      hv = h[S+1];
      p0 = hv[1:0];
      p1 = hv[3:2];
      if (p0 == 2'b11 || p1 == 2'b11) merr = 1'b1;
      check("err_model", bus.ERR, merr);
      check("r_select_pairing", ((bus.R == 2'b00) == (bus.SELECT == 2'b00)), 1);
      check("one_enable_low", !(!bus.L0e && !bus.L1e), 1);
      if (bus.SELECT == 2'b01) check("sel0_en_low", bus.L0e, 0);
      if (bus.SELECT == 2'b10) check("sel1_en_low", bus.L1e, 0);
      if (prev_r == 2'b00 && bus.R != 2'b00) begin
        v0 = (p0 == 2'b01) || (p0 == 2'b10);
        v1 = (p1 == 2'b01) || (p1 == 2'b10);
        check("token_has_valid_source", v0 | v1, 1);
        w = v1 && (!v0 || !mlast);
        check("token_r", bus.R, w ? p1 : p0);
        check("token_select", bus.SELECT, w ? 2'b10 : 2'b01);
        grants.push_back(w ? 1 : 0);
        cur_win = w ? 1 : 0;
      end
      if (cur_win == 0 && !prev_l0e && bus.L0e) begin mlast = 1'b0; cur_win = -1; end
      if (cur_win == 1 && !prev_l1e && bus.L1e) begin mlast = 1'b1; cur_win = -1; end
      prev_r = bus.R; prev_l0e = bus.L0e; prev_l1e = bus.L1e;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // what: 0 R valid, 1 R neutral, 2 L0e high, 3 L1e high
  task automatic wait_until(input string name, input int what);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge CLK);
      case (what)
        0: ok = (bus.R != 2'b00);
        1: ok = (bus.R == 2'b00);
        2: ok = bus.L0e;
        default: ok = bus.L1e;
      endcase
    end
    check(name, ok, 1);
  endtask

  task automatic finish_token(input int chn);
    step();
    bus.Re = 1'b0; bus.SELECTe = 1'b0;
    wait_until("fin_r_neutral", 1);
    step();
    bus.Re = 1'b1; bus.SELECTe = 1'b1;
    if (chn == 0) bus.L0 = 2'b00; else bus.L1 = 2'b00;
    wait_until("fin_en_high", chn == 0 ? 2 : 3);
  endtask

  task automatic pulse_reset();
    step();
    RESET = 1'b1;
    step();
    RESET = 1'b0;
  endtask

  logic [1:0] exp_r [4];
  logic [1:0] sel_seen;
  int         exp_g [4];

  initial begin
    RESET = 1'b1;
    bus.L0 = 2'b00; bus.L1 = 2'b00; bus.Re = 1'b0; bus.SELECTe = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_r", bus.R, 2'b00);
    check("rst_select", bus.SELECT, 2'b00);
    check("rst_l0e", bus.L0e, 1);
    check("rst_l1e", bus.L1e, 1);
    check("rst_err", bus.ERR, 0);

    // Single L0 token with exact latencies.
    RESET = 1'b0;
    bus.L0 = 2'b10; bus.Re = 1'b1; bus.SELECTe = 1'b1;
    repeat (3) @(negedge CLK);
    check("t1_r_before", bus.R, 2'b00);
    @(negedge CLK);
    check("t1_r", bus.R, 2'b10);
    check("t1_select", bus.SELECT, 2'b01);
    check("t1_l0e", bus.L0e, 0);
    check("t1_l1e", bus.L1e, 1);
    step();
    bus.Re = 1'b0; bus.SELECTe = 1'b0;
    repeat (3) @(negedge CLK);
    check("t1_hold_r", bus.R, 2'b10);
    @(negedge CLK);
    check("t1_drop_r", bus.R, 2'b00);
    check("t1_drop_select", bus.SELECT, 2'b00);
    step();
    bus.Re = 1'b1; bus.SELECTe = 1'b1; bus.L0 = 2'b00;
    repeat (3) @(negedge CLK);
    check("t1_l0e_before", bus.L0e, 0);
    @(negedge CLK);
    check("t1_l0e_rise", bus.L0e, 1);

    // L1 alone.
    step();
    bus.L1 = 2'b01;
    wait_until("t2_wait", 0);
    check("t2_r", bus.R, 2'b01);
    check("t2_select", bus.SELECT, 2'b10);
    check("t2_l1e", bus.L1e, 0);
    check("t2_l0e", bus.L0e, 1);
    finish_token(1);

    // Simultaneous arrival after reset, four tokens.
    pulse_reset();
    grants.delete();
    bus.L0 = 2'b01; bus.L1 = 2'b10;
    exp_r[0] = 2'b10; exp_r[1] = 2'b01; exp_r[2] = 2'b10; exp_r[3] = 2'b01;
    exp_g[0] = 1; exp_g[1] = 0; exp_g[2] = 1; exp_g[3] = 0;
    for (int i = 0; i < 4; i++) begin
      wait_until("t3_wait", 0);
      check("t3_order_r", bus.R, exp_r[i]);
      sel_seen = bus.SELECT;
      step();
      bus.Re = 1'b0; bus.SELECTe = 1'b0;
      wait_until("t3_r_neutral", 1);
      step();
      bus.Re = 1'b1; bus.SELECTe = 1'b1;
      if (sel_seen == 2'b01) bus.L0 = 2'b00; else bus.L1 = 2'b00;
      wait_until("t3_en_high", sel_seen == 2'b01 ? 2 : 3);
      if (i < 2) begin
        step();
        if (sel_seen == 2'b01) bus.L0 = 2'b01; else bus.L1 = 2'b10;
      end
    end
    check("t3_grant_count", grants.size(), 4);
    for (int i = 0; i < 4 && i < grants.size(); i++)
      check("t3_grant_src", grants[i], exp_g[i]);

    // Re held low blocks forwarding.
    step();
    bus.Re = 1'b0;
    repeat (4) @(negedge CLK);
    step();
    bus.L0 = 2'b10;
    repeat (10) @(negedge CLK);
    check("t4_r_blocked", bus.R, 2'b00);
    check("t4_l0e_high", bus.L0e, 1);
    step();
    bus.Re = 1'b1;
    repeat (3) @(negedge CLK);
    check("t4_r_before", bus.R, 2'b00);
    @(negedge CLK);
    check("t4_r", bus.R, 2'b10);
    finish_token(0);

    // Illegal code sets sticky ERR and is never forwarded.
    step();
    bus.L0 = 2'b11;
    repeat (6) @(negedge CLK);
    check("t5_r", bus.R, 2'b00);
    check("t5_err", bus.ERR, 1);
    check("t5_l0e", bus.L0e, 1);
    step();
    bus.L0 = 2'b00;
    repeat (6) @(negedge CLK);
    check("t5_err_sticky", bus.ERR, 1);

    // Asynchronous reset in SEND.
    step();
    bus.L0 = 2'b10;
    wait_until("t6_wait", 0);
    check("t6_r_send", bus.R, 2'b10);
    @(posedge CLK);
    #3;
    RESET = 1'b1;
    #1;
    check("t6_r", bus.R, 2'b00);
    check("t6_select", bus.SELECT, 2'b00);
    check("t6_l0e", bus.L0e, 1);
    check("t6_l1e", bus.L1e, 1);
    check("t6_err", bus.ERR, 0);
    step();
    bus.L0 = 2'b00;
    RESET = 1'b0;
    repeat (6) @(negedge CLK);
    check("t6_idle_r", bus.R, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
